// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a pending-write scoreboard.
//
// Two combinational read ports and one synchronous write port. Decode issue marks a
// destination register pending. Write-back clears that mark. Hazard logic can then
// stall on busy source operands.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   resetN       : asynchronous active-low reset; clears registers, pending bits, count
//   writeEn      : write strobe from write-back
//   writeR       : write register index
//   writeData    : write data
//   issueEn      : decode issue strobe; marks issueR pending
//   issueR       : destination index of the issued instruction
//   readR1/2     : read port indices
//   readData1/2  : combinational read data
//   readBusy1/2  : the read index has an outstanding write
//   pendingCount : number of registers currently pending (registered)
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              writeEn,
   input  logic [ADDR_W-1:0] writeR,
   input  logic [DATA_W-1:0] writeData,
   input  logic              issueEn,
   input  logic [ADDR_W-1:0] issueR,
   input  logic [ADDR_W-1:0] readR1,
   input  logic [ADDR_W-1:0] readR2,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              readBusy1,
   output logic              readBusy2,
   output logic [ADDR_W:0]   pendingCount
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [DEPTH-1:0]  pendingNext;
   logic [ADDR_W:0]   countQ;
   logic [ADDR_W:0]   countNext;
   logic              writeOk;
   logic              issueOk;
   logic              setNew;
   logic              clearOld;

   always_comb begin
      writeOk = writeEn && !(ZERO_REG && (writeR == '0));
      issueOk = issueEn && !(ZERO_REG && (issueR == '0));

      // A write that coincides with an issue to the same index leaves the bit set,
      // so it only counts as a clear when no issue targets the same register.
      setNew   = issueOk && !pending[issueR];
      clearOld = writeOk && pending[writeR] && !(issueOk && (issueR == writeR));

      pendingNext = pending;
      if (writeOk) pendingNext[writeR] = 1'b0;
      if (issueOk) pendingNext[issueR] = 1'b1;

      countNext = countQ;
      if (setNew && !clearOld)      countNext = countQ + CountOne;
      else if (clearOld && !setNew) countNext = countQ - CountOne;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pending <= '0;
         countQ  <= '0;
      end else begin
         if (writeOk) regs[writeR] <= writeData;
         pending <= pendingNext;
         countQ  <= countNext;
      end
   end

   // The resetN gating keeps the bypass path from leaking writeData while in reset.
   function automatic logic [DATA_W-1:0] readMux(input logic [ADDR_W-1:0] r);
      logic [DATA_W-1:0] d;
      if (!resetN)                           d = '0;
      else if (ZERO_REG && (r == '0))        d = '0;
      else if (BYPASS && writeOk && (writeR == r)) d = writeData;
      else                                   d = regs[r];
      return d;
   endfunction

   function automatic logic busyMux(input logic [ADDR_W-1:0] r);
      return resetN && pending[r] && !(BYPASS && writeOk && (writeR == r));
   endfunction

   always_comb begin
      readData1 = readMux(readR1);
      readData2 = readMux(readR2);
      readBusy1 = busyMux(readR1);
      readBusy2 = busyMux(readR2);
   end

   assign pendingCount = countQ;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: self-checking bench for reg_file_sb.
// dutA uses BYPASS=1 and dutB uses BYPASS=0. Vectors carry expected pre-edge outputs.
module tb_reg_file_sb;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic [5:0]  pc;
   } expect_t;

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ir;
      logic [4:0]  r1;
      logic [4:0]  r2;
      expect_t     exp;
   } vec_t;

   logic clk = 1'b0;
   logic resetN;

   logic        aWe, aIe, bWe, bIe;
   logic [4:0]  aWr, aIr, aR1, aR2, bWr, bIr, bR1, bR2;
   logic [31:0] aWd, bWd;
   logic [31:0] aD1, aD2, bD1, bD2;
   logic        aB1, aB2, bB1, bB2;
   logic [5:0]  aPc, bPc;

   int compared = 0;
   int mismatched = 0;
   expect_t sbQ[$];
   vec_t vecs[20];
   vec_t bVecs[4];

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
      .clk(clk), .resetN(resetN),
      .writeEn(aWe), .writeR(aWr), .writeData(aWd),
      .issueEn(aIe), .issueR(aIr),
      .readR1(aR1), .readR2(aR2),
      .readData1(aD1), .readData2(aD2),
      .readBusy1(aB1), .readBusy2(aB2),
      .pendingCount(aPc)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dutB (
      .clk(clk), .resetN(resetN),
      .writeEn(bWe), .writeR(bWr), .writeData(bWd),
      .issueEn(bIe), .issueR(bIr),
      .readR1(bR1), .readR2(bR2),
      .readData1(bD1), .readData2(bD2),
      .readBusy1(bB1), .readBusy2(bB2),
      .pendingCount(bPc)
   );

   function automatic vec_t mkVec(input logic we, input int wr, input logic [31:0] wd,
                                  input logic ie, input int ir, input int r1, input int r2,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic b1, input logic b2, input int pc);
      vec_t v;
      v.we = we; v.wr = 5'(wr); v.wd = wd; v.ie = ie; v.ir = 5'(ir);
      v.r1 = 5'(r1); v.r2 = 5'(r2);
      v.exp.d1 = d1; v.exp.d2 = d2; v.exp.b1 = b1; v.exp.b2 = b2; v.exp.pc = 6'(pc);
      return v;
   endfunction

   task automatic cmp(input string name, input string field, input logic [31:0] got,
                      input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s %s: got %h expected %h", name, field, got, want);
      end
   endtask

   // Pops the oldest expectation and compares it with the sampled outputs of one DUT.
   task automatic checkOut(input string name, input bit useB);
      expect_t e;
      if (sbQ.size() == 0) begin
         compared++; mismatched++;
         $display("FAIL %s scoreboard: got empty queue expected an entry", name);
         return;
      end
      e = sbQ.pop_front();
      if (!useB) begin
         cmp(name, "readData1", aD1, e.d1);
         cmp(name, "readData2", aD2, e.d2);
         cmp(name, "readBusy1", 32'(aB1), 32'(e.b1));
         cmp(name, "readBusy2", 32'(aB2), 32'(e.b2));
         cmp(name, "pendingCount", 32'(aPc), 32'(e.pc));
      end else begin
         cmp(name, "readData1", bD1, e.d1);
         cmp(name, "readData2", bD2, e.d2);
         cmp(name, "readBusy1", 32'(bB1), 32'(e.b1));
         cmp(name, "readBusy2", 32'(bB2), 32'(e.b2));
         cmp(name, "pendingCount", 32'(bPc), 32'(e.pc));
      end
   endtask

   task automatic idleAll();
      aWe = 0; aWr = 0; aWd = 0; aIe = 0; aIr = 0; aR1 = 0; aR2 = 0;
      bWe = 0; bWr = 0; bWd = 0; bIe = 0; bIr = 0; bR1 = 0; bR2 = 0;
   endtask

   // One clock cycle: drive after the edge, sample at the falling edge, commit at next edge.
   task automatic step(input vec_t v, input bit useB, input string name);
      @(posedge clk);
      #1;
      idleAll();
      if (!useB) begin
         aWe = v.we; aWr = v.wr; aWd = v.wd; aIe = v.ie; aIr = v.ir; aR1 = v.r1; aR2 = v.r2;
      end else begin
         bWe = v.we; bWr = v.wr; bWd = v.wd; bIe = v.ie; bIr = v.ir; bR1 = v.r1; bR2 = v.r2;
      end
      sbQ.push_back(v.exp);
      @(negedge clk);
      checkOut(name, useB);
   endtask

   task automatic checkNow(input expect_t e, input string name);
      sbQ.push_back(e);
      checkOut(name, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      expect_t e;

      //            we wr wd            ie ir r1 r2  d1            d2            b1 b2 pc
      vecs[0]  = mkVec(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0);
      vecs[1]  = mkVec(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0);
      vecs[2]  = mkVec(1, 8, 32'h3,        0, 0, 8, 8, 32'h3,        32'h3,        0, 0, 0);
      vecs[3]  = mkVec(1, 9, 32'h8,        0, 0, 9, 8, 32'h8,        32'h3,        0, 0, 0);
      vecs[4]  = mkVec(0, 0, 32'h0,        1, 5, 5, 9, 32'h0,        32'h8,        0, 0, 0);
      vecs[5]  = mkVec(0, 0, 32'h0,        0, 0, 5, 5, 32'h0,        32'h0,        1, 1, 1);
      vecs[6]  = mkVec(1, 5, 32'h55,       0, 0, 5, 8, 32'h55,       32'h3,        0, 0, 1);
      vecs[7]  = mkVec(0, 0, 32'h0,        0, 0, 5, 7, 32'h55,       32'h0,        0, 0, 0);
      vecs[8]  = mkVec(0, 0, 32'h0,        1, 7, 7, 7, 32'h0,        32'h0,        0, 0, 0);
      vecs[9]  = mkVec(1, 7, 32'h77,       1, 7, 7, 7, 32'h77,       32'h77,       0, 0, 1);
      vecs[10] = mkVec(0, 0, 32'h0,        0, 0, 7, 5, 32'h77,       32'h55,       1, 0, 1);
      vecs[11] = mkVec(0, 0, 32'h0,        1, 7, 7, 8, 32'h77,       32'h3,        1, 0, 1);
      vecs[12] = mkVec(0, 0, 32'h0,        0, 0, 7, 9, 32'h77,       32'h8,        1, 0, 1);
      vecs[13] = mkVec(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1);
      vecs[14] = mkVec(0, 0, 32'h0,        0, 0, 0, 5, 32'h0,        32'h55,       0, 0, 1);
      vecs[15] = mkVec(1, 7, 32'h70,       1, 1, 1, 7, 32'h0,        32'h70,       0, 0, 1);
      vecs[16] = mkVec(0, 0, 32'h0,        1, 2, 1, 7, 32'h0,        32'h70,       1, 0, 1);
      vecs[17] = mkVec(0, 0, 32'h0,        1, 3, 2, 1, 32'h0,        32'h0,        1, 1, 2);
      vecs[18] = mkVec(0, 0, 32'h0,        1, 4, 3, 4, 32'h0,        32'h0,        1, 0, 3);
      vecs[19] = mkVec(0, 0, 32'h0,        0, 0, 4, 1, 32'h0,        32'h0,        1, 1, 4);

      bVecs[0] = mkVec(1, 3, 32'h11,       0, 0, 3, 3, 32'h0,        32'h0,        0, 0, 0);
      bVecs[1] = mkVec(0, 0, 32'h0,        1, 3, 3, 3, 32'h11,       32'h11,       0, 0, 0);
      bVecs[2] = mkVec(1, 3, 32'hA,        0, 0, 3, 3, 32'h11,       32'h11,       1, 1, 1);
      bVecs[3] = mkVec(0, 0, 32'h0,        0, 0, 3, 3, 32'hA,        32'hA,        0, 0, 0);

      idleAll();
      resetN = 1'b0;
      #12 resetN = 1'b1;

      // Every index reads zero and idle straight out of reset.
      e = '{d1: 32'h0, d2: 32'h0, b1: 1'b0, b2: 1'b0, pc: 6'h0};
      for (int i = 0; i < 32; i++) begin
         aR1 = 5'(i);
         aR2 = 5'(31 - i);
         #1;
         checkNow(e, $sformatf("resetRead%0d", i));
      end

      for (int i = 0; i < 20; i++) step(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // Reset asserted between edges must clear everything immediately,
      // even with a bypassing write in flight.
      @(posedge clk);
      #2;
      aWe = 1; aWr = 5'd8; aWd = 32'hFFFF_FFFF; aIe = 0; aR1 = 5'd8; aR2 = 5'd4;
      #1;
      e = '{d1: 32'hFFFF_FFFF, d2: 32'h0, b1: 1'b0, b2: 1'b1, pc: 6'd4};
      checkNow(e, "preReset");
      resetN = 1'b0;
      #1;
      e = '{d1: 32'h0, d2: 32'h0, b1: 1'b0, b2: 1'b0, pc: 6'd0};
      checkNow(e, "midReset");
      aWe = 0;
      #1 resetN = 1'b1;
      #1;
      checkNow(e, "postReset");

      for (int i = 0; i < 4; i++) step(bVecs[i], 1'b1, $sformatf("noBypass%0d", i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
